valu_op_sequencer: RTL and testbench

- Front-end controller sitting directly upstream of the 4-lane 128-bit FP ALU array. Also captures that array's results.
- Accepts 32-bit words from the host interface (Caravel wishbone/LA glue) and assembles 128-bit operand A and operand B.
- Drives the array's operand/select/CE load sequence, waits a settle window, then registers the 128-bit result and the per-lane Exception/Overflow/Underflow flags.
- Reports completion with a done pulse and a sticky status.

---
 rtl/valu_pkg.sv | 21 ++
 rtl/valu_word_packer.sv | 60 ++++++
 rtl/valu_op_sequencer.sv | 156 +++++++++++++++
 tb/tb_valu_op_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/valu_pkg.sv
// rtl/valu_pkg.sv - shared widths, flag layout and FSM states for the vector ALU op sequencer
package valu_pkg;

   localparam int LANE_W  = 32;
   localparam int VEC_W   = 128;
   localparam int FLAG_W  = 12;

   // o_flags layout: {unf[3:0], ovf[3:0], exc[3:0]}
   localparam int EXC_LSB = 0;
   localparam int OVF_LSB = 4;
   localparam int UNF_LSB = 8;

   typedef enum logic [2:0] {
      COLLECT,
      LOAD_A,
      LOAD_B,
      SETTLE,
      CAPTURE
   } state_t;

endpackage

// File: rtl/valu_word_packer.sv
// rtl/valu_word_packer.sv - packs eight 32-bit host words into 128-bit operands A and B
module valu_word_packer
   import valu_pkg::*;
(
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_en,      // sequencer idle, words may be taken
   input  logic              i_clear,   // result captured, start a fresh operand set
   input  logic              i_wvalid,
   input  logic [LANE_W-1:0] i_wdata,
   output logic              o_wready,
   output logic              o_full,
   output logic [VEC_W-1:0]  o_a,
   output logic [VEC_W-1:0]  o_b
);

   // r_count is the next word slot; r_full marks the count==8 condition
   logic [2:0]       r_count;
   logic             r_full;
   logic [VEC_W-1:0] r_a;
   logic [VEC_W-1:0] r_b;
   logic             w_accept;

   assign o_wready = i_en & ~r_full;
   assign w_accept = i_wvalid & o_wready;
   assign o_full   = r_full;
   assign o_a      = r_a;
   assign o_b      = r_b;

   // word slot counter, saturating at eight words until the capture clears it
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= 3'd0;
         r_full  <= 1'b0;
      end else if (i_clear) begin
         r_count <= 3'd0;
         r_full  <= 1'b0;
      end else if (w_accept) begin
         r_count <= r_count + 3'd1;
         if (r_count == 3'd7) begin
            r_full <= 1'b1;
         end
      end
   end

   // steer each accepted word into its lane; slot bit 2 selects operand B
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_a <= '0;
         r_b <= '0;
      end else if (w_accept) begin
         if (r_count[2]) begin
            r_b[r_count[1:0]*LANE_W +: LANE_W] <= i_wdata;
         end else begin
            r_a[r_count[1:0]*LANE_W +: LANE_W] <= i_wdata;
         end
      end
   end

endmodule

// File: rtl/valu_op_sequencer.sv
// rtl/valu_op_sequencer.sv - operand load / settle / capture sequencer for the 4-lane FP ALU array
module valu_op_sequencer
   import valu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int LANES         = 4
)
(
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_wvalid,
   input  logic [LANE_W-1:0] i_wdata,
   output logic              o_wready,
   input  logic              i_start,
   input  logic [3:0]        i_op,
   output logic [VEC_W-1:0]  o_operand,
   output logic              o_operand_sel,
   output logic              o_ce,
   output logic [3:0]        o_alu_op,
   input  logic [VEC_W-1:0]  i_alu_result,
   input  logic [LANES-1:0]  i_exc,
   input  logic [LANES-1:0]  i_ovf,
   input  logic [LANES-1:0]  i_unf,
   output logic [VEC_W-1:0]  o_result,
   output logic [FLAG_W-1:0] o_flags,
   output logic              o_done,
   output logic              o_busy
);

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_settle;
   logic [3:0]        r_alu_op;
   logic [VEC_W-1:0]  r_result;
   logic [FLAG_W-1:0] r_flags;
   logic              r_done;

   logic              w_full;
   logic [VEC_W-1:0]  w_a;
   logic [VEC_W-1:0]  w_b;
   logic              w_start_acc;
   logic              w_ce;
   logic              w_sel;
   logic              w_busy;
   logic [VEC_W-1:0]  w_operand;

   valu_word_packer u_packer (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_en     (r_state == COLLECT),
      .i_clear  (r_state == CAPTURE),
      .i_wvalid (i_wvalid),
      .i_wdata  (i_wdata),
      .o_wready (o_wready),
      .o_full   (w_full),
      .o_a      (w_a),
      .o_b      (w_b)
   );

   // state register; reset drops CE/operand immediately since they decode from state
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_next;
      end
   end

   // next state and ALU array drive; B stays loaded with CE high through capture
   always_comb begin
      w_next      = r_state;
      w_start_acc = 1'b0;
      w_ce        = 1'b0;
      w_sel       = 1'b0;
      w_busy      = 1'b1;
      w_operand   = '0;
      case (r_state)
         COLLECT: begin
            w_busy = 1'b0;
            if (i_start && w_full) begin
               w_start_acc = 1'b1;
               w_next      = LOAD_A;
            end
         end
         LOAD_A: begin
            w_ce      = 1'b1;
            w_sel     = 1'b1;
            w_operand = w_a;
            w_next    = LOAD_B;
         end
         LOAD_B: begin
            w_ce      = 1'b1;
            w_operand = w_b;
            w_next    = SETTLE;
         end
         SETTLE: begin
            w_ce      = 1'b1;
            w_operand = w_b;
            if (r_settle == 4'd0) begin
               w_next = CAPTURE;
            end
         end
         CAPTURE: begin
            w_ce      = 1'b1;
            w_operand = w_b;
            w_next    = COLLECT;
         end
         default: begin
            w_busy = 1'b0;
            w_next = COLLECT;
         end
      endcase
   end

   // settle down-counter, armed while B is first presented
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_settle <= 4'd0;
      end else if (r_state == LOAD_B) begin
         r_settle <= 4'(SETTLE_CYCLES - 1);
      end else if (r_state == SETTLE && r_settle != 4'd0) begin
         r_settle <= r_settle - 4'd1;
      end
   end

   // opcode latch at start, result/flag capture and the one-cycle done pulse
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_alu_op <= 4'd0;
         r_result <= '0;
         r_flags  <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == CAPTURE);
         if (w_start_acc) begin
            r_alu_op <= i_op;
         end
         if (r_state == CAPTURE) begin
            r_result                  <= i_alu_result;
            r_flags[EXC_LSB +: LANES] <= i_exc;
            r_flags[OVF_LSB +: LANES] <= i_ovf;
            r_flags[UNF_LSB +: LANES] <= i_unf;
         end
      end
   end

   assign o_operand     = w_operand;
   assign o_operand_sel = w_sel;
   assign o_ce          = w_ce;
   assign o_busy        = w_busy;
   assign o_alu_op      = r_alu_op;
   assign o_result      = r_result;
   assign o_flags       = r_flags;
   assign o_done        = r_done;

endmodule

// File: tb/tb_valu_op_sequencer.sv
// tb/tb_valu_op_sequencer.sv - scoreboard bench for valu_op_sequencer at SETTLE_CYCLES 1 and 4
module tb_valu_op_sequencer;
   import valu_pkg::*;

   localparam int S0 = 1;
   localparam int S1 = 4;
   localparam logic [3:0] EXC = 4'b0101;
   localparam logic [3:0] OVF = 4'b0010;
   localparam logic [3:0] UNF = 4'b1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst     [2];
   logic         wvalid  [2];
   logic [31:0]  wdata   [2];
   logic         start   [2];
   logic [3:0]   op      [2];
   logic         wready  [2];
   logic [127:0] operand [2];
   logic         sel     [2];
   logic         ce      [2];
   logic [3:0]   alu_op  [2];
   logic [127:0] alu_res [2];
   logic [127:0] result  [2];
   logic [11:0]  flags   [2];
   logic         done    [2];
   logic         busy    [2];
   logic [127:0] stub_a  [2];
   logic [127:0] stub_b  [2];

   typedef struct {
      logic [127:0] res;
      logic [11:0]  flg;
      logic [3:0]   op;
      int           cyc;
   } exp_t;

   exp_t         sb0[$];
   exp_t         sb1[$];
   logic [31:0]  mw    [2][8];
   int           mcount[2];
   logic [127:0] mlast [2];
   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;

   valu_op_sequencer #(.SETTLE_CYCLES(S0)) u0 (
      .clk(clk), .i_rst(rst[0]), .i_wvalid(wvalid[0]), .i_wdata(wdata[0]), .o_wready(wready[0]),
      .i_start(start[0]), .i_op(op[0]), .o_operand(operand[0]), .o_operand_sel(sel[0]), .o_ce(ce[0]),
      .o_alu_op(alu_op[0]), .i_alu_result(alu_res[0]), .i_exc(EXC), .i_ovf(OVF), .i_unf(UNF),
      .o_result(result[0]), .o_flags(flags[0]), .o_done(done[0]), .o_busy(busy[0])
   );

   valu_op_sequencer #(.SETTLE_CYCLES(S1)) u1 (
      .clk(clk), .i_rst(rst[1]), .i_wvalid(wvalid[1]), .i_wdata(wdata[1]), .o_wready(wready[1]),
      .i_start(start[1]), .i_op(op[1]), .o_operand(operand[1]), .o_operand_sel(sel[1]), .o_ce(ce[1]),
      .o_alu_op(alu_op[1]), .i_alu_result(alu_res[1]), .i_exc(EXC), .i_ovf(OVF), .i_unf(UNF),
      .o_result(result[1]), .o_flags(flags[1]), .o_done(done[1]), .o_busy(busy[1])
   );

   // stub ALU array: registers A/B on CE, result is the lane-wise XOR
   always @(posedge clk) begin
      if (ce[0]) begin
         if (sel[0]) stub_a[0] <= operand[0];
         else        stub_b[0] <= operand[0];
      end
      if (ce[1]) begin
         if (sel[1]) stub_a[1] <= operand[1];
         else        stub_b[1] <= operand[1];
      end
      cyc <= cyc + 1;
   end
   assign alu_res[0] = stub_a[0] ^ stub_b[0];
   assign alu_res[1] = stub_a[1] ^ stub_b[1];

   function automatic int settle(input int k);
      return (k == 0) ? S0 : S1;
   endfunction

   function automatic logic [127:0] vec_a(input int k);
      return {mw[k][3], mw[k][2], mw[k][1], mw[k][0]};
   endfunction

   function automatic logic [127:0] vec_b(input int k);
      return {mw[k][7], mw[k][6], mw[k][5], mw[k][4]};
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic mon_done(input int k);
      exp_t e;
      bit   empty;
      if (k == 0) begin
         empty = (sb0.size() == 0);
         if (!empty) e = sb0.pop_front();
      end else begin
         empty = (sb1.size() == 0);
         if (!empty) e = sb1.pop_front();
      end
      if (empty) begin
         check($sformatf("spurious_done%0d", k), 128'(done[k]), 128'd0);
      end else begin
         check($sformatf("result%0d", k), result[k], e.res);
         check($sformatf("flags%0d", k), 128'(flags[k]), 128'(e.flg));
         check($sformatf("op_at_done%0d", k), 128'(alu_op[k]), 128'(e.op));
         check($sformatf("latency%0d", k), 128'(cyc - e.cyc), 128'(3 + settle(k)));
         mlast[k] = e.res;
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (done[k] === 1'b1) mon_done(k);
      end
   end

   task automatic put_word(input int k, input logic [31:0] w);
      logic exp_rdy;
      @(negedge clk);
      exp_rdy   = (mcount[k] < 8);
      wvalid[k] = 1'b1;
      wdata[k]  = w;
      check($sformatf("wready%0d_slot%0d", k, mcount[k]), 128'(wready[k]), 128'(exp_rdy));
      if (exp_rdy) begin
         mw[k][mcount[k]] = w;
         mcount[k]++;
      end
      @(posedge clk);
      #1;
      wvalid[k] = 1'b0;
   endtask

   task automatic do_start(input int k, input logic [3:0] o);
      logic acc;
      exp_t e;
      @(negedge clk);
      start[k] = 1'b1;
      op[k]    = o;
      acc      = (mcount[k] == 8);
      @(posedge clk);
      #1;
      start[k] = 1'b0;
      check($sformatf("busy_after_start%0d", k), 128'(busy[k]), 128'(acc));
      if (acc) begin
         e.res = vec_a(k) ^ vec_b(k);
         e.flg = 12'h825;
         e.op  = o;
         e.cyc = cyc;
         if (k == 0) sb0.push_back(e);
         else        sb1.push_back(e);
         mcount[k] = 0;
      end
   endtask

   // cycle-by-cycle view of the array drive from LOAD_A to the done cycle
   task automatic trace(input int k, input logic [3:0] o, input bit offer);
      logic [127:0] a;
      logic [127:0] b;
      int           nb;
      int           s;
      a  = vec_a(k);
      b  = vec_b(k);
      s  = settle(k);
      nb = 0;
      for (int i = 0; i <= 3 + s; i++) begin
         @(negedge clk);
         check($sformatf("ce%0d_c%0d", k, i), 128'(ce[k]), 128'(i <= 2 + s));
         check($sformatf("sel%0d_c%0d", k, i), 128'(sel[k]), 128'(i == 0));
         check($sformatf("operand%0d_c%0d", k, i), operand[k],
               (i == 0) ? a : ((i <= 2 + s) ? b : 128'd0));
         check($sformatf("alu_op%0d_c%0d", k, i), 128'(alu_op[k]), 128'(o));
         if (i < 3 + s) check($sformatf("hold%0d_c%0d", k, i), result[k], mlast[k]);
         if (ce[k] && !sel[k]) nb++;
         if (offer) begin
            if (i <= 2 + s) begin
               check($sformatf("busy_wready%0d_c%0d", k, i), 128'(wready[k]), 128'd0);
               wvalid[k] = 1'b1;
               wdata[k]  = $urandom;
               start[k]  = 1'b1;
               op[k]     = 4'($urandom_range(15, 0));
            end else begin
               wvalid[k] = 1'b0;
               start[k]  = 1'b0;
               op[k]     = o;
            end
         end
      end
      check($sformatf("b_ce_cycles%0d", k), 128'(nb), 128'(2 + s));
   endtask

   task automatic wait_idle(input int k);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check($sformatf("done_timeout%0d", k), 128'(busy[k]), 128'd0);
   endtask

   initial begin
      logic [127:0] first;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; wvalid[k] = 1'b0; wdata[k] = '0; start[k] = 1'b0; op[k] = '0;
         mcount[k] = 0; mlast[k] = '0; stub_a[k] = '0; stub_b[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_result", result[k], 128'd0);
         check("rst_flags", 128'(flags[k]), 128'd0);
         check("rst_done", 128'(done[k]), 128'd0);
         check("rst_busy", 128'(busy[k]), 128'd0);
         check("rst_ce", 128'(ce[k]), 128'd0);
         check("rst_sel", 128'(sel[k]), 128'd0);
         check("rst_operand", operand[k], 128'd0);
         check("rst_alu_op", 128'(alu_op[k]), 128'd0);
      end
      @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      #1;
      check("rst_wready0", 128'(wready[0]), 128'd1);
      check("rst_wready1", 128'(wready[1]), 128'd1);

      // reset in the middle of SETTLE
      for (int i = 0; i < 8; i++) put_word(1, $urandom);
      do_start(1, 4'h5);
      repeat (3) @(negedge clk);
      #2;
      rst[1] = 1'b1;
      #1;
      check("midrst_ce", 128'(ce[1]), 128'd0);
      check("midrst_busy", 128'(busy[1]), 128'd0);
      check("midrst_operand", operand[1], 128'd0);
      sb1.delete();
      mcount[1] = 0;
      mlast[1]  = '0;
      @(negedge clk);
      rst[1] = 1'b0;
      repeat (10) @(negedge clk);
      check("midrst_result", result[1], 128'd0);
      check("midrst_flags", 128'(flags[1]), 128'd0);
      check("midrst_wready", 128'(wready[1]), 128'd1);

      // reference operands, op 3
      put_word(0, 32'h3F800000); put_word(0, 32'h40000000);
      put_word(0, 32'h40400000); put_word(0, 32'h40800000);
      for (int i = 0; i < 4; i++) put_word(0, 32'h3F800000);
      do_start(0, 4'h3);
      trace(0, 4'h3, 1'b0);
      wait_idle(0);

      // early start ignored, ninth word refused
      for (int i = 0; i < 5; i++) put_word(0, $urandom);
      do_start(0, 4'h7);
      for (int i = 0; i < 3; i++) put_word(0, $urandom);
      put_word(0, 32'hDEADBEEF);
      do_start(0, 4'h9);
      trace(0, 4'h9, 1'b0);
      wait_idle(0);

      // long settle, words and starts offered while busy
      for (int i = 0; i < 8; i++) put_word(1, $urandom);
      do_start(1, 4'h6);
      trace(1, 4'h6, 1'b1);
      wait_idle(1);

      // back-to-back operations
      for (int i = 0; i < 8; i++) put_word(0, $urandom);
      do_start(0, 4'hA);
      trace(0, 4'hA, 1'b0);
      first = vec_a(0) ^ vec_b(0);
      for (int i = 0; i < 8; i++) begin
         put_word(0, $urandom);
         check("b2b_hold", result[0], first);
      end
      do_start(0, 4'hC);
      trace(0, 4'hC, 1'b0);
      wait_idle(0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
